// File: rtl/instr_encoder.sv
// Encodes decoded instruction field bundles into 32-bit MIPS-style words.
// Each word is tagged with a byte address and queued in a 2-entry output FIFO.
module instr_encoder #(
   parameter logic [31:0] RESET_BASE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   input  logic        base_load,
   input  logic [31:0] base_addr,
   input  logic        halt_clr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic [31:0] out_addr,
   output logic        err,
   output logic        halted
);

   localparam logic [2:0] KIND_R    = 3'd0;
   localparam logic [2:0] KIND_LW   = 3'd1;
   localparam logic [2:0] KIND_SW   = 3'd2;
   localparam logic [2:0] KIND_ADDI = 3'd3;
   localparam logic [2:0] KIND_BEQ  = 3'd4;
   localparam logic [2:0] KIND_J    = 3'd5;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t      state;
   state_t      state_n;

   // FIFO entry 0 is the head shown on the outputs, entry 1 the tail
   logic [31:0] word_p0;
   logic [31:0] addr_p0;
   logic        vld_p0;
   logic [31:0] word_p1;
   logic [31:0] addr_p1;
   logic        vld_p1;

   logic [31:0] word0_n;
   logic [31:0] addr0_n;
   logic        vld0_n;
   logic [31:0] word1_n;
   logic [31:0] addr1_n;
   logic        vld1_n;

   logic [31:0] cnt;
   logic [31:0] cnt_n;
   logic        err_q;
   logic        err_n;

   logic        legal;
   logic        full;
   logic        pop;
   logic        accept;
   logic        push;
   logic [31:0] enc_word;
   logic [31:0] tag;

   function automatic logic is_legal(input logic [2:0] kind);
      return (kind <= KIND_J);
   endfunction

   function automatic logic [31:0] encode(
      input logic [2:0]  kind,
      input logic [4:0]  f_rs,
      input logic [4:0]  f_rt,
      input logic [4:0]  f_rd,
      input logic [5:0]  f_funct,
      input logic [15:0] f_imm,
      input logic [25:0] f_target
   );
      logic [31:0] w;
      w = 32'h0000_0000;
      case (kind)
         KIND_R:    w = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, f_funct};
         KIND_LW:   w = {OP_LW, f_rs, f_rt, f_imm};
         KIND_SW:   w = {OP_SW, f_rs, f_rt, f_imm};
         KIND_ADDI: w = {OP_ADDI, f_rs, f_rt, f_imm};
         KIND_BEQ:  w = {OP_BEQ, f_rs, f_rt, f_imm};
         KIND_J:    w = {OP_J, f_target};
         default:   w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   assign legal    = is_legal(in_kind);
   assign full     = vld_p0 & vld_p1;
   assign pop      = vld_p0 & out_ready;
   // Gated with rst_n so the handshake is closed for the whole reset window
   assign in_ready = rst_n & (state == ST_RUN) & (~full | pop);
   assign accept   = in_valid & in_ready;
   assign push     = accept & legal;
   assign enc_word = encode(in_kind, rs, rt, rd, funct, imm, target);
   assign tag      = base_load ? base_addr : cnt;

   assign out_valid = vld_p0;
   assign out_word  = word_p0;
   assign out_addr  = addr_p0;
   assign err       = err_q;
   assign halted    = (state == ST_HALT);

   always_comb begin
      state_n = state;
      err_n   = 1'b0;
      case (state)
         ST_RUN: begin
            if (accept && !legal) begin
               state_n = ST_HALT;
               err_n   = 1'b1;
            end
         end
         ST_HALT: begin
            if (halt_clr) begin
               state_n = ST_RUN;
            end
         end
         default: state_n = ST_RUN;
      endcase
   end

   always_comb begin
      cnt_n = cnt;
      if (push) begin
         cnt_n = tag + 32'd4;
      end else if (base_load) begin
         cnt_n = base_addr;
      end
   end

   always_comb begin
      word0_n = word_p0;
      addr0_n = addr_p0;
      vld0_n  = vld_p0;
      word1_n = word_p1;
      addr1_n = addr_p1;
      vld1_n  = vld_p1;
      if (pop) begin
         word0_n = word_p1;
         addr0_n = addr_p1;
         vld0_n  = vld_p1;
         vld1_n  = 1'b0;
         if (push) begin
            if (vld_p1) begin
               word1_n = enc_word;
               addr1_n = tag;
               vld1_n  = 1'b1;
            end else begin
               word0_n = enc_word;
               addr0_n = tag;
               vld0_n  = 1'b1;
            end
         end
      end else if (push) begin
         if (!vld_p0) begin
            word0_n = enc_word;
            addr0_n = tag;
            vld0_n  = 1'b1;
         end else begin
            word1_n = enc_word;
            addr1_n = tag;
            vld1_n  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_n;
      end
   end

   // Registered stage: FIFO entries, address counter and error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_p0 <= 32'h0000_0000;
         addr_p0 <= 32'h0000_0000;
         vld_p0  <= 1'b0;
         word_p1 <= 32'h0000_0000;
         addr_p1 <= 32'h0000_0000;
         vld_p1  <= 1'b0;
         cnt     <= RESET_BASE;
         err_q   <= 1'b0;
      end else begin
         word_p0 <= word0_n;
         addr_p0 <= addr0_n;
         vld_p0  <= vld0_n;
         word_p1 <= word1_n;
         addr_p1 <= addr1_n;
         vld_p1  <= vld1_n;
         cnt     <= cnt_n;
         err_q   <= err_n;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: encoding, addressing, FIFO backpressure,
// illegal-kind halt handling and asynchronous reset.
module tb_instr_encoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_kind;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [25:0] target;
   logic        base_load;
   logic [31:0] base_addr;
   logic        halt_clr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [31:0] out_addr;
   logic        err;
   logic        halted;

   int checks;
   int errors;

   instr_encoder #(.RESET_BASE(32'h0000_0000)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_kind(in_kind),
      .rs(rs),
      .rt(rt),
      .rd(rd),
      .funct(funct),
      .imm(imm),
      .target(target),
      .base_load(base_load),
      .base_addr(base_addr),
      .halt_clr(halt_clr),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_word(out_word),
      .out_addr(out_addr),
      .err(err),
      .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [2:0] k, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input logic [5:0] f, input logic [15:0] i,
                      input logic [25:0] t);
      in_valid = 1'b1;
      in_kind  = k;
      rs       = a;
      rt       = b;
      rd       = c;
      funct    = f;
      imm      = i;
      target   = t;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_kind = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0;
      funct = 6'd0; imm = 16'd0; target = 26'd0; base_load = 1'b0; base_addr = 32'd0;
      halt_clr = 1'b0; out_ready = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_word !== 32'h0) begin errors++; $display("FAIL rst_out_word: got %h expected 00000000", out_word); end
      checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL rst_out_addr: got %h expected 00000000", out_addr); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
      step(); step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_held: got %b expected 0", in_ready); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_lw();
      out_ready = 1'b1;
      put(3'd1, 5'd2, 5'd3, 5'd17, 6'h3f, 16'h0010, 26'h3ff_ffff);
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lw_valid: got %b expected 1", out_valid); end
      checks++; if (out_word !== 32'h8C43_0010) begin errors++; $display("FAIL lw_word: got %h expected 8c430010", out_word); end
      checks++; if (out_addr !== 32'h0000_0000) begin errors++; $display("FAIL lw_addr: got %h expected 00000000", out_addr); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lw_drained: got %b expected 0", out_valid); end
   endtask

   task automatic test_rtype_j();
      out_ready = 1'b1;
      base_load = 1'b1; base_addr = 32'h0000_0000;
      put(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'hBEEF, 26'h155_5555);
      step();
      base_load = 1'b0;
      put(3'd5, 5'd31, 5'd31, 5'd31, 6'h3f, 16'hFFFF, 26'h000_0100);
      checks++; if (out_word !== 32'h0022_1820) begin errors++; $display("FAIL r_word: got %h expected 00221820", out_word); end
      checks++; if (out_addr !== 32'h0000_0000) begin errors++; $display("FAIL r_addr: got %h expected 00000000", out_addr); end
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL j_valid: got %b expected 1", out_valid); end
      checks++; if (out_word !== 32'h0800_0100) begin errors++; $display("FAIL j_word: got %h expected 08000100", out_word); end
      checks++; if (out_addr !== 32'h0000_0004) begin errors++; $display("FAIL j_addr: got %h expected 00000004", out_addr); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL j_drained: got %b expected 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      put(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_a: got %b expected 1", in_ready); end
      step();
      put(3'd2, 5'd4, 5'd5, 5'd0, 6'd0, 16'hFFFF, 26'd0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_b: got %b expected 1", in_ready); end
      step();
      put(3'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0004, 26'd0);
      base_load = 1'b1; base_addr = 32'h0000_1000;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b expected 0", in_ready); end
      step();
      base_load = 1'b0;
      checks++; if (out_word !== 32'h2022_0005) begin errors++; $display("FAIL b2b_head_word: got %h expected 20220005", out_word); end
      checks++; if (out_addr !== 32'h0000_0008) begin errors++; $display("FAIL b2b_head_addr: got %h expected 00000008", out_addr); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_still_blocked: got %b expected 0", in_ready); end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_pop: got %b expected 1", in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (out_word !== 32'hAC85_FFFF) begin errors++; $display("FAIL b2b_second_word: got %h expected ac85ffff", out_word); end
      checks++; if (out_addr !== 32'h0000_000C) begin errors++; $display("FAIL b2b_second_addr: got %h expected 0000000c", out_addr); end
      step();
      checks++; if (out_word !== 32'h8C01_0004) begin errors++; $display("FAIL b2b_third_word: got %h expected 8c010004", out_word); end
      checks++; if (out_addr !== 32'h0000_1000) begin errors++; $display("FAIL b2b_third_addr: got %h expected 00001000", out_addr); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
   endtask

   task automatic test_wrap();
      out_ready = 1'b1;
      base_load = 1'b1; base_addr = 32'hFFFF_FFFC;
      put(3'd3, 5'd3, 5'd3, 5'd9, 6'h15, 16'hFFFF, 26'h2aa_aaaa);
      step();
      base_load = 1'b0;
      put(3'd4, 5'd1, 5'd2, 5'd30, 6'h01, 16'hFFFE, 26'h3ff_ffff);
      checks++; if (out_word !== 32'h2063_FFFF) begin errors++; $display("FAIL wrap_addi_word: got %h expected 2063ffff", out_word); end
      checks++; if (out_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addi_addr: got %h expected fffffffc", out_addr); end
      step();
      in_valid = 1'b0;
      checks++; if (out_word !== 32'h1022_FFFE) begin errors++; $display("FAIL wrap_beq_word: got %h expected 1022fffe", out_word); end
      checks++; if (out_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_beq_addr: got %h expected 00000000", out_addr); end
      step();
   endtask

   task automatic test_illegal();
      out_ready = 1'b0;
      put(3'd3, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0);
      step();
      put(3'd7, 5'd5, 5'd6, 5'd7, 6'h2a, 16'h1234, 26'h0abcdef);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready_before: got %b expected 1", in_ready); end
      step();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err_pulse: got %b expected 1", err); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ill_halted: got %b expected 1", halted); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ill_ready_halt: got %b expected 0", in_ready); end
      checks++; if (out_word !== 32'h2000_0001) begin errors++; $display("FAIL ill_queued_word: got %h expected 20000001", out_word); end
      checks++; if (out_addr !== 32'h0000_0004) begin errors++; $display("FAIL ill_queued_addr: got %h expected 00000004", out_addr); end
      in_valid = 1'b0;
      step();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_err_clear: got %b expected 0", err); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ill_not_pushed: got %b expected 1", out_valid); end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill_drain: got %b expected 0", out_valid); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ill_still_halted: got %b expected 1", halted); end
      halt_clr = 1'b1;
      step();
      halt_clr = 1'b0;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL ill_released: got %b expected 0", halted); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready_after: got %b expected 1", in_ready); end
      put(3'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0010, 26'd0);
      step();
      in_valid = 1'b0;
      checks++; if (out_addr !== 32'h0000_0008) begin errors++; $display("FAIL ill_next_addr: got %h expected 00000008", out_addr); end
      checks++; if (out_word !== 32'h8C43_0010) begin errors++; $display("FAIL ill_next_word: got %h expected 8c430010", out_word); end
      step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      put(3'd2, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0002, 26'd0);
      step();
      put(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'd0);
      step();
      in_valid = 1'b0;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL mid_pre_halted: got %b expected 1", halted); end
      checks++; if (out_word !== 32'hAC21_0002) begin errors++; $display("FAIL mid_pre_word: got %h expected ac210002", out_word); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mid_halted: got %b expected 0", halted); end
      checks++; if (out_word !== 32'h0) begin errors++; $display("FAIL mid_out_word: got %h expected 00000000", out_word); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", err); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b expected 0", in_ready); end
      step();
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_release: got %b expected 1", in_ready); end
      out_ready = 1'b1;
      put(3'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0010, 26'd0);
      step();
      in_valid = 1'b0;
      checks++; if (out_addr !== 32'h0000_0000) begin errors++; $display("FAIL mid_base_addr: got %h expected 00000000", out_addr); end
      checks++; if (out_word !== 32'h8C43_0010) begin errors++; $display("FAIL mid_word: got %h expected 8c430010", out_word); end
      step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_lw();
      test_rtype_j();
      test_back_to_back();
      test_wrap();
      test_illegal();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter RESET_BASE, default 32'h0000_0000, SHALL set the address assigned to the first instruction accepted after reset.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-004 Port in_valid, input, 1, SHALL flag that a field bundle is presented.
REQ-005 Port in_ready, output, 1, SHALL flag that the block can accept a bundle this cycle.
REQ-006 Port in_kind, input, 3, SHALL select the class: 0 R-type, 1 LW, 2 SW, 3 ADDI, 4 BEQ, 5 J, 6-7 illegal.
REQ-007 Ports rs/rt/rd, input, 5 each, SHALL be the register fields; funct, input, 6; imm, input, 16; target, input, 26.
REQ-008 Port base_load, input, 1, and base_addr, input, 32, SHALL reload the address counter.
REQ-009 Port halt_clr, input, 1, SHALL release the HALT state.
REQ-010 Port out_valid, output, 1, and out_ready, input, 1, SHALL form the output handshake.
REQ-011 Port out_word, output, 32, SHALL carry the encoded instruction; out_addr, output, 32, its byte address.
REQ-012 Port err, output, 1, SHALL pulse for one cycle when an illegal kind is accepted.
REQ-013 Port halted, output, 1, SHALL be high while in HALT.

Function
REQ-014 Transfer SHALL occur on an input edge where in_valid and in_ready are both high; likewise output on out_valid and out_ready.
REQ-015 Encoding SHALL be: R-type {6'b000000, rs, rt, rd, 5'b0, funct}; LW op 100011, SW op 101011, ADDI op 001000, BEQ op 000100, each {op, rs, rt, imm}; J {6'b000010, target}.
REQ-016 Unused input fields for a class SHALL be ignored.
REQ-017 Encoded words SHALL be stored in a 2-entry registered FIFO holding {word, addr}; out_word/out_addr SHALL show the head entry; out_valid SHALL equal FIFO non-empty.
REQ-018 Latency SHALL be one cycle: a bundle accepted at edge N SHALL be visible with out_valid high immediately after edge N; no combinational path from in_* to out_*.
REQ-019 in_ready SHALL be high only in state RUN and when the FIFO is not full, or full with a pop this cycle (out_valid and out_ready).
REQ-020 Simultaneous push and pop SHALL keep occupancy unchanged and preserve order.
REQ-021 Address counter SHALL tag each legal accepted word, then increment by 4, wrapping modulo 2^32 (32'hFFFF_FFFC followed by 32'h0000_0000).
REQ-022 base_load SHALL set the counter to base_addr; if a legal accept coincides, that word SHALL take base_addr and the counter SHALL become base_addr+4.
REQ-023 base_load SHALL not alter entries already in the FIFO.
REQ-024 FSM states SHALL be RUN and HALT; RUN->HALT when an illegal kind is accepted; HALT->RUN on halt_clr; halt_clr in RUN SHALL have no effect.
REQ-025 An accepted illegal bundle SHALL not be pushed and SHALL not advance the counter; err SHALL be high the cycle after acceptance only.
REQ-026 In HALT the FIFO SHALL continue to drain normally.

Reset
REQ-027 On rst_n low, immediately and independently of clk: FIFO empty, out_valid 0, out_word 0, out_addr 0, err 0, halted 0, state RUN, counter RESET_BASE.
REQ-028 Reset asserted mid-operation SHALL discard all FIFO contents and any pending HALT.
REQ-029 in_ready SHALL be 0 while rst_n is low and 1 on the first cycle after release.

Verification
REQ-030 LW rs=2 rt=3 imm=16'h0010, out_ready=1 -> next cycle out_word 32'h8C43_0010, out_addr 0.
REQ-031 R-type rs=1 rt=2 rd=3 funct=6'h20, then J target=26'h0000100 -> words 32'h0022_1820 at addr 0, 32'h0800_0100 at addr 4.
REQ-032 out_ready=0, three back-to-back bundles -> two accepted, in_ready low on third; after out_ready=1 words emerge in order, third then accepted.
REQ-033 base_load base_addr=32'hFFFF_FFFC with ADDI accept, then BEQ -> addrs 32'hFFFF_FFFC then 32'h0000_0000.
REQ-034 in_kind=7 accepted -> err one-cycle pulse, halted=1, in_ready=0, queued words still drain; halt_clr -> in_ready=1, next legal word takes the unchanged counter value.
REQ-035 rst_n pulsed low with FIFO full and halted=1 -> out_valid 0, halted 0, next accepted word at RESET_BASE.
